controle_coprocessador: RTL and testbench

Sequencer for the 5x5 8-bit matrix coprocessor. It accepts one host operation at a time (opcode, matrix size, operands A/B), latches the operands, and drives a level start to exactly one operation unit (transposta, soma, multiplicacao, ...). It waits for that unit's done, captures its 200-bit result and reports completion or error. It sits between the host interface and the bank of operation units; all units share its registered operand buses.

---
 rtl/controle_coprocessador.sv | 162 ++++++++++++++++
 tb/tb_controle_coprocessador.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_coprocessador.sv
`default_nettype none
// ============================================================================
// Module      : controle_coprocessador
// Description : Sequencer for the 5x5 8-bit matrix coprocessor. Accepts one
//               host operation at a time, latches its operands, drives a
//               start level to exactly one operation unit, waits for that
//               unit's done and captures its result, reporting completion or
//               error (bad opcode, bad size, or timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module controle_coprocessador #(
    parameter int NUM_OPS = 8,
    parameter int MAT_W   = 200,
    parameter int TIMEOUT = 255,
    parameter int MIN_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2:0]               opcode,
    input  logic [2:0]               tamanho,
    input  logic [MAT_W-1:0]         matrizA,
    input  logic [MAT_W-1:0]         matrizB,
    input  logic [NUM_OPS*MAT_W-1:0] resultados,
    input  logic [NUM_OPS-1:0]       done_op,
    output logic [NUM_OPS-1:0]       start_op,
    output logic [MAT_W-1:0]         op_a,
    output logic [MAT_W-1:0]         op_b,
    output logic [2:0]               op_tam,
    output logic [MAT_W-1:0]         matriz_resultante,
    output logic                     busy,
    output logic                     done,
    output logic                     erro
);

    // Wait counter only has to reach TIMEOUT; it saturates instead of wrapping.
    localparam int                CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  C_MIN_LAT = CNT_W'(MIN_LAT);
    localparam logic [31:0]       C_NUM_OPS = 32'(NUM_OPS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_WAIT     = 2'd2
    } state_t;

    state_t               state_q;
    logic [2:0]           sel_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_OPS-1:0]   start_op_q;
    logic [MAT_W-1:0]     op_a_q;
    logic [MAT_W-1:0]     op_b_q;
    logic [2:0]           op_tam_q;
    logic [MAT_W-1:0]     result_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 erro_q;

    logic [NUM_OPS-1:0]   sel_onehot_w;
    logic [MAT_W-1:0]     sel_result_w;
    logic                 sel_done_w;
    logic                 sel_valid_w;
    logic                 tam_valid_w;

    // Decode the latched opcode into a one-hot unit select and its result slice.
    always_comb begin
        sel_onehot_w = '0;
        sel_result_w = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (32'(sel_q) == 32'(k)) begin
                sel_onehot_w[k] = 1'b1;
                sel_result_w    = resultados[k*MAT_W +: MAT_W];
            end
        end
    end

    // Only the selected unit's done counts; other units' done bits are ignored.
    assign sel_done_w  = |(done_op & sel_onehot_w);
    assign sel_valid_w = (32'(sel_q) < C_NUM_OPS);
    assign tam_valid_w = (op_tam_q >= 3'd2) && (op_tam_q <= 3'd5);

    // Sequencer: IDLE latches a request, DISPATCH validates and starts a unit,
    // WAIT collects the result or aborts on timeout. All outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= 3'd0;
            cnt_q      <= '0;
            start_op_q <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_tam_q   <= 3'd0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sel_q    <= opcode;
                        op_a_q   <= matrizA;
                        op_b_q   <= matrizB;
                        op_tam_q <= tamanho;
                        erro_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    if (!sel_valid_w || !tam_valid_w) begin
                        erro_q  <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        start_op_q <= sel_onehot_w;
                        cnt_q      <= '0;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    // The first MIN_LAT cycles mask a done left over from a previous run.
                    if ((cnt_q >= C_MIN_LAT) && sel_done_w) begin
                        result_q   <= sel_result_w;
                        start_op_q <= '0;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (cnt_q == C_TIMEOUT) begin
                        start_op_q <= '0;
                        erro_q     <= 1'b1;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    start_op_q <= '0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_op          = start_op_q;
    assign op_a              = op_a_q;
    assign op_b              = op_b_q;
    assign op_tam            = op_tam_q;
    assign matriz_resultante = result_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign erro              = erro_q;

endmodule
`default_nettype wire

// File: tb/tb_controle_coprocessador.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_coprocessador
// Description : Self-checking bench for controle_coprocessador with a bank of
//               model operation units and a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_coprocessador;

    localparam int NUM_OPS = 6;
    localparam int MAT_W   = 200;
    localparam int TIMEOUT = 255;
    localparam int MIN_LAT = 1;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic [2:0]               opcode = 3'd0;
    logic [2:0]               tamanho = 3'd0;
    logic [MAT_W-1:0]         matrizA = '0;
    logic [MAT_W-1:0]         matrizB = '0;
    logic [NUM_OPS*MAT_W-1:0] resultados = '0;
    logic [NUM_OPS-1:0]       done_op = '0;
    logic [NUM_OPS-1:0]       start_op;
    logic [MAT_W-1:0]         op_a;
    logic [MAT_W-1:0]         op_b;
    logic [2:0]               op_tam;
    logic [MAT_W-1:0]         matriz_resultante;
    logic                     busy;
    logic                     done;
    logic                     erro;

    controle_coprocessador #(
        .NUM_OPS(NUM_OPS), .MAT_W(MAT_W), .TIMEOUT(TIMEOUT), .MIN_LAT(MIN_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .tamanho(tamanho),
        .matrizA(matrizA), .matrizB(matrizB), .resultados(resultados), .done_op(done_op),
        .start_op(start_op), .op_a(op_a), .op_b(op_b), .op_tam(op_tam),
        .matriz_resultante(matriz_resultante), .busy(busy), .done(done), .erro(erro)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [MAT_W-1:0] rand_mat();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[32*i +: 32] = $urandom;
        return t[MAT_W-1:0];
    endfunction

    // Unit k's function: 0 = transpose A, 1 = A+B, others = (A^B)+k, per element.
    function automatic logic [MAT_W-1:0] unit_fn(input int k, input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
        logic [MAT_W-1:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                if (k == 0)      r[40*i+8*j +: 8] = a[40*j+8*i +: 8];
                else if (k == 1) r[40*i+8*j +: 8] = a[40*i+8*j +: 8] + b[40*i+8*j +: 8];
                else             r[40*i+8*j +: 8] = (a[40*i+8*j +: 8] ^ b[40*i+8*j +: 8]) + 8'(k);
            end
        end
        return r;
    endfunction

    // ---------------- model operation units ----------------
    int cfg_lat   = 1;     // cycles after seeing start before done; -1 = never
    bit cfg_stuck = 1'b0;  // every done bit held high, even before start
    bit cfg_noise = 1'b0;  // idle units toggle done randomly
    int ucnt [NUM_OPS];

    // Units react to their start level; a result is valid only while done is up.
    always @(negedge clk) begin
        logic d;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (start_op[k]) ucnt[k] = ucnt[k] + 1;
            else             ucnt[k] = -1;
            if (cfg_stuck)        d = 1'b1;
            else if (start_op[k]) d = (cfg_lat >= 0) && (ucnt[k] >= cfg_lat);
            else                  d = cfg_noise ? 1'($urandom % 2) : 1'b0;
            done_op[k] = d;
            resultados[k*MAT_W +: MAT_W] = d ? unit_fn(k, op_a, op_b) : rand_mat();
        end
    end

    // ---------------- reference model ----------------
    // m_step counts edges since the request was accepted (0 = idle).
    logic [NUM_OPS-1:0] m_start_op = '0;
    logic [MAT_W-1:0]   m_a = '0, m_b = '0, m_res = '0;
    logic [2:0]         m_tam = '0, m_sel = '0;
    logic               m_busy = 1'b0, m_done = 1'b0, m_erro = 1'b0;
    int                 m_step = 0;

    // Outputs expected after each edge, derived from the operation's timeline.
    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_start_op = '0; m_a = '0; m_b = '0; m_res = '0; m_tam = '0; m_sel = '0;
            m_busy = 1'b0; m_done = 1'b0; m_erro = 1'b0; m_step = 0;
        end else begin
            m_done = 1'b0;
            if (m_step == 0) begin
                if (start) begin
                    m_sel = opcode; m_a = matrizA; m_b = matrizB; m_tam = tamanho;
                    m_erro = 1'b0; m_step = 1;
                end
            end else if (m_step == 1) begin
                if (int'(m_sel) >= NUM_OPS || m_tam < 2 || m_tam > 5) begin
                    m_erro = 1'b1; m_done = 1'b1; m_step = 0;
                end else begin
                    m_start_op = '0; m_start_op[m_sel] = 1'b1; m_step = 2;
                end
            end else begin
                w = m_step - 2;
                if (w >= MIN_LAT && done_op[m_sel]) begin
                    m_res = resultados[m_sel*MAT_W +: MAT_W];
                    m_start_op = '0; m_done = 1'b1; m_step = 0;
                end else if (w == TIMEOUT) begin
                    m_start_op = '0; m_erro = 1'b1; m_done = 1'b1; m_step = 0;
                end else begin
                    m_step++;
                end
            end
            m_busy = (m_step != 0);
        end
    end

    // Every cycle out of reset, all DUT outputs must match the model.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("start_op", start_op, m_start_op);
            check("start_op_onehot0", $onehot0(start_op), 1);
            check("op_a", op_a, m_a);
            check("op_b", op_b, m_b);
            check("op_tam", op_tam, m_tam);
            check("matriz_resultante", matriz_resultante, m_res);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("erro", erro, m_erro);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue_op(input logic [2:0] opc, input logic [2:0] tam,
                            input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
        @(negedge clk);
        opcode = opc; tamanho = tam; matrizA = a; matrizB = b; start = 1'b1;
        @(posedge clk); #1;
    endtask

    // Waits for done; returns edges counted from the call (-1 if the budget ran out).
    task automatic wait_done(input int budget, input bit hold, input bit noise, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
            if (noise) begin
                start   = hold ? 1'b1 : 1'($urandom % 2);
                opcode  = 3'($urandom);
                tamanho = 3'($urandom);
                matrizA = rand_mat();
                matrizB = rand_mat();
            end else if (!hold) begin
                start = 1'b0;
            end
        end
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL wait_done: no done within %0d cycles", budget);
        end
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        logic [MAT_W-1:0] a, b, exp_t, prev_res;
        int lat;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_start_op", start_op, 0);
        check("reset_busy_done_erro", {busy, done, erro}, 0);
        check("reset_matriz", matriz_resultante, 0);
        check("reset_op_a", op_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Transpose of A[r][c] = 10r+c on unit 0
        a = '0; exp_t = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                a[40*r+8*c +: 8]     = 8'(10*r + c);
                exp_t[40*r+8*c +: 8] = 8'(10*c + r);
            end
        end
        b = rand_mat();
        cfg_lat = 1; cfg_noise = 1'b0;
        issue_op(3'd0, 3'd5, a, b);
        @(posedge clk); #1;
        check("transp_start_op_E1", start_op, 6'b000001);
        wait_done(20, 1'b0, 1'b0, lat);
        check("transp_latency", 1 + lat, 3);
        check("transp_result", matriz_resultante, exp_t);
        check("transp_erro", erro, 0);

        // Invalid opcode, invalid size, then a valid op clears erro
        issue_op(3'd7, 3'd5, rand_mat(), rand_mat());
        wait_done(20, 1'b0, 1'b0, lat);
        check("bad_opcode_latency", lat, 1);
        check("bad_opcode_erro", erro, 1);
        issue_op(3'd0, 3'd1, rand_mat(), rand_mat());
        wait_done(20, 1'b0, 1'b0, lat);
        check("bad_tam_latency", lat, 1);
        check("bad_tam_erro", erro, 1);
        cfg_lat = 2;
        issue_op(3'd1, 3'd3, rand_mat(), rand_mat());
        check("erro_cleared_on_accept", erro, 0);
        wait_done(20, 1'b0, 1'b0, lat);
        check("lat2_latency", lat, 4);

        // Done stuck high before start: masked at E2, taken at E3
        cfg_stuck = 1'b1;
        a = rand_mat(); b = rand_mat();
        issue_op(3'd3, 3'd4, a, b);
        wait_done(20, 1'b0, 1'b0, lat);
        cfg_stuck = 1'b0;
        prev_res = unit_fn(3, a, b);
        check("stuck_latency", lat, 3);
        check("stuck_result", matriz_resultante, prev_res);

        // Timeout with the selected unit never answering
        cfg_lat = -1; cfg_noise = 1'b1;
        issue_op(3'd2, 3'd2, rand_mat(), rand_mat());
        wait_done(400, 1'b0, 1'b1, lat);
        check("timeout_latency", lat, 2 + TIMEOUT);
        check("timeout_erro", erro, 1);
        check("timeout_result_kept", matriz_resultante, prev_res);
        check("timeout_start_op", start_op, 0);

        // start held through an op: re-accepted on the cycle right after done
        cfg_lat = 1;
        issue_op(3'd4, 3'd5, rand_mat(), rand_mat());
        wait_done(20, 1'b1, 1'b1, lat);
        check("hold_latency", lat, 3);
        @(posedge clk); #1;
        check("hold_reaccept_busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        wait_done(400, 1'b0, 1'b0, lat);

        // Asynchronous reset while waiting on unit 2
        cfg_lat = -1;
        issue_op(3'd2, 3'd3, rand_mat(), rand_mat());
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_start_op", start_op, 6'b000100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_start_op", start_op, 0);
        check("async_reset_flags", {busy, done, erro}, 0);
        check("async_reset_regs", op_a | op_b | matriz_resultante | MAT_W'(op_tam), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Noisy neighbours while unit 2 takes three cycles
        cfg_lat = 3; cfg_noise = 1'b1;
        a = rand_mat(); b = rand_mat();
        issue_op(3'd2, 3'd5, a, b);
        wait_done(20, 1'b0, 1'b1, lat);
        check("noise_latency", lat, 5);
        check("noise_result", matriz_resultante, unit_fn(2, a, b));

        // Randomized operations, with spurious start pulses mid-operation
        for (int t = 0; t < 40; t++) begin
            cfg_lat = int'($urandom_range(0, 4));
            issue_op(3'($urandom), 3'($urandom_range(1, 6)), rand_mat(), rand_mat());
            wait_done(40, 1'b0, 1'($urandom % 2), lat);
        end

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
